// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD write arbiter: FSM encodings, field widths
// and the round-robin pointer advance helper.
package lcd_pkg;

   localparam int LCD_COLS = 16;
   localparam int COL_W    = $clog2(LCD_COLS);
   localparam int CHAR_W   = 8;
   localparam int IDX_W    = 2;
   localparam int CNT_W    = 3;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_ISSUE     = 2'd1,
      ST_WAIT_RISE = 2'd2,
      ST_WAIT_FALL = 2'd3
   } lcd_state_e;

   // Next round-robin start position after requester 'cur' was served.
   function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] cur,
                                                 input int nreq);
      logic [IDX_W-1:0] res;
      if (int'(cur) >= nreq - 1) begin
         res = '0;
      end else begin
         res = cur + 2'd1;
      end
      return res;
   endfunction

endpackage

// File: rtl/lcd_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first requesting index at or after the
// pointer, wrapping, returned as one-hot vector plus binary index.
module rr_pick
   import lcd_pkg::*;
#(
   parameter int NREQ = 2
) (
   input  logic [NREQ-1:0]  req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [NREQ-1:0]  win_oh_o,
   output logic [IDX_W-1:0] win_idx_o,
   output logic             any_o
);

   // Scan requesters starting at the pointer; the first hit wins.
   always_comb begin
      int pos;
      win_oh_o  = '0;
      win_idx_o = '0;
      any_o     = 1'b0;
      pos       = 0;
      for (int i = 0; i < NREQ; i++) begin
         pos = (int'(ptr_i) + i) % NREQ;
         for (int j = 0; j < NREQ; j++) begin
            if (!any_o && (j == pos) && req_i[j]) begin
               win_oh_o[j] = 1'b1;
               win_idx_o   = IDX_W'(j);
               any_o       = 1'b1;
            end else begin
               any_o = any_o;
            end
         end
      end
   end

endmodule

// File: rtl/lcd_write_arbiter.sv
// Shares the single LCD character-write port between NREQ requesters.
// Round-robin, one character per grant, with an optional burst lock held by
// the last granted requester. BUSY_WAIT must be in 1..8 (3-bit wait counter).
module lcd_write_arbiter
   import lcd_pkg::*;
#(
   parameter int NREQ      = 2,
   parameter int BUSY_WAIT = 4
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic [NREQ-1:0]        req_i,
   input  logic [NREQ-1:0]        lock_i,
   input  logic [NREQ-1:0]        row_i,
   input  logic [COL_W*NREQ-1:0]  col_i,
   input  logic [CHAR_W*NREQ-1:0] char_i,
   output logic [NREQ-1:0]        ack_o,
   output logic                   lcd_row,
   output logic [COL_W-1:0]       lcd_col,
   output logic [CHAR_W-1:0]      lcd_char,
   output logic                   lcd_we,
   input  logic                   lcd_busy,
   output logic [IDX_W-1:0]       owner_o,
   output logic                   active_o
);

   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(BUSY_WAIT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   lcd_state_e        state_q, state_d;
   logic [IDX_W-1:0]  ptr_q, ptr_d;
   logic [IDX_W-1:0]  lock_own_q, lock_own_d;
   logic              lock_vld_q, lock_vld_d;
   logic [IDX_W-1:0]  owner_q, owner_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [NREQ-1:0]   ack_q, ack_d;
   logic              row_q, row_d;
   logic [COL_W-1:0]  col_q, col_d;
   logic [CHAR_W-1:0] chr_q, chr_d;
   logic              we_q, we_d;
   logic              active_q, active_d;

   logic [NREQ-1:0]   rr_oh_s;
   logic [IDX_W-1:0]  rr_idx_s;
   logic              rr_any_s;
   logic [NREQ-1:0]   lock_oh_s;
   logic              lock_hit_s;
   logic [NREQ-1:0]   win_oh_s;
   logic [IDX_W-1:0]  win_idx_s;
   logic              win_lock_s;
   logic              win_row_s;
   logic [COL_W-1:0]  win_col_s;
   logic [CHAR_W-1:0] win_chr_s;
   logic [IDX_W-1:0]  ptr_done_s;

   rr_pick #(
      .NREQ (NREQ)
   ) u_rr_pick (
      .req_i     (req_i),
      .ptr_i     (ptr_q),
      .win_oh_o  (rr_oh_s),
      .win_idx_o (rr_idx_s),
      .any_o     (rr_any_s)
   );

   // Lock owner as one-hot; it overrides round-robin only while its req is high.
   always_comb begin
      lock_oh_s = '0;
      for (int k = 0; k < NREQ; k++) begin
         lock_oh_s[k] = (lock_own_q == IDX_W'(k));
      end
      lock_hit_s = lock_vld_q && ((lock_oh_s & req_i) != '0);
   end

   // Final winner and its row/column/character, muxed from the one-hot vector.
   always_comb begin
      win_oh_s  = lock_hit_s ? lock_oh_s  : rr_oh_s;
      win_idx_s = lock_hit_s ? lock_own_q : rr_idx_s;
      win_lock_s = ((win_oh_s & lock_i) != '0);
      win_row_s = 1'b0;
      win_col_s = '0;
      win_chr_s = '0;
      for (int k = 0; k < NREQ; k++) begin
         win_row_s = win_row_s | (row_i[k] & win_oh_s[k]);
         win_col_s = win_col_s | (col_i[k*COL_W +: COL_W] & {COL_W{win_oh_s[k]}});
         win_chr_s = win_chr_s | (char_i[k*CHAR_W +: CHAR_W] & {CHAR_W{win_oh_s[k]}});
      end
      // A held lock keeps the pointer where it is so the burst owner is not skipped.
      ptr_done_s = lock_vld_q ? ptr_q : rr_next(owner_q, NREQ);
   end

   // Next-state logic for the grant / strobe / busy-handshake sequence.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      lock_own_d = lock_own_q;
      lock_vld_d = lock_vld_q;
      owner_d    = owner_q;
      cnt_d      = cnt_q;
      ack_d      = '0;
      row_d      = row_q;
      col_d      = col_q;
      chr_d      = chr_q;
      we_d       = 1'b0;
      active_d   = active_q;

      case (state_q)
         ST_IDLE: begin
            // An idle lock owner releases the lock so others are not starved.
            if (lock_vld_q && !lock_hit_s) begin
               lock_vld_d = 1'b0;
            end else begin
               lock_vld_d = lock_vld_q;
            end
            if (rr_any_s && !lcd_busy) begin
               ack_d      = win_oh_s;
               owner_d    = win_idx_s;
               row_d      = win_row_s;
               col_d      = win_col_s;
               chr_d      = win_chr_s;
               active_d   = 1'b1;
               lock_vld_d = win_lock_s;
               lock_own_d = win_idx_s;
               cnt_d      = '0;
               state_d    = ST_ISSUE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            we_d    = 1'b1;
            cnt_d   = '0;
            state_d = ST_WAIT_RISE;
         end
         ST_WAIT_RISE: begin
            if (lcd_busy) begin
               state_d = ST_WAIT_FALL;
            end else if (cnt_q >= WAIT_LAST) begin
               // Driver never acknowledged; treat the write as done.
               active_d = 1'b0;
               ptr_d    = ptr_done_s;
               state_d  = ST_IDLE;
            end else begin
               cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 3'd1;
            end
         end
         ST_WAIT_FALL: begin
            if (!lcd_busy) begin
               active_d = 1'b0;
               ptr_d    = ptr_done_s;
               state_d  = ST_IDLE;
            end else begin
               state_d = ST_WAIT_FALL;
            end
         end
         default: begin
            active_d = 1'b0;
            state_d  = ST_IDLE;
         end
      endcase
   end

   // State and output registers; reset clears everything, including the lock.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q    <= ST_IDLE;
         ptr_q      <= '0;
         lock_own_q <= '0;
         lock_vld_q <= 1'b0;
         owner_q    <= '0;
         cnt_q      <= '0;
         ack_q      <= '0;
         row_q      <= 1'b0;
         col_q      <= '0;
         chr_q      <= '0;
         we_q       <= 1'b0;
         active_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         lock_own_q <= lock_own_d;
         lock_vld_q <= lock_vld_d;
         owner_q    <= owner_d;
         cnt_q      <= cnt_d;
         ack_q      <= ack_d;
         row_q      <= row_d;
         col_q      <= col_d;
         chr_q      <= chr_d;
         we_q       <= we_d;
         active_q   <= active_d;
      end
   end

   assign ack_o    = ack_q;
   assign lcd_row  = row_q;
   assign lcd_col  = col_q;
   assign lcd_char = chr_q;
   assign lcd_we   = we_q;
   assign owner_o  = owner_q;
   assign active_o = active_q;

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// Directed bench for lcd_write_arbiter with an LCD-driver busy model and a
// scoreboard of expected writes checked on every lcd_we strobe.
module tb_lcd_write_arbiter;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic [1:0]  req_i = 2'b00;
   logic [1:0]  lock_i = 2'b00;
   logic [1:0]  row_i = 2'b01;
   logic [7:0]  col_i = {4'd9, 4'd3};
   logic [15:0] char_i = {8'h41, 8'h35};
   logic [1:0]  ack_o;
   logic        lcd_row;
   logic [3:0]  lcd_col;
   logic [7:0]  lcd_char;
   logic        lcd_we;
   logic        lcd_busy;
   logic [1:0]  owner_o;
   logic        active_o;

   logic        m_busy = 1'b0;
   logic        force_busy = 1'b0;
   int          auto_en = 1;
   int          rise_dly = 3;
   int          busy_len = 3;
   int          t_v = 0;
   int          l_v = 0;

   int          checks = 0;
   int          errors = 0;

   typedef struct packed {
      logic [1:0] own;
      logic       row;
      logic [3:0] col;
      logic [7:0] ch;
   } exp_t;
   exp_t sb[$];

   assign lcd_busy = m_busy | force_busy;

   lcd_write_arbiter #(.NREQ(2), .BUSY_WAIT(4)) dut (
      .CLK      (CLK),
      .RST      (RST),
      .req_i    (req_i),
      .lock_i   (lock_i),
      .row_i    (row_i),
      .col_i    (col_i),
      .char_i   (char_i),
      .ack_o    (ack_o),
      .lcd_row  (lcd_row),
      .lcd_col  (lcd_col),
      .lcd_char (lcd_char),
      .lcd_we   (lcd_we),
      .lcd_busy (lcd_busy),
      .owner_o  (owner_o),
      .active_o (active_o)
   );

   initial forever #5 CLK = ~CLK;

   initial begin
      #300000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic push_exp(input int idx);
      exp_t e;
      e.own = 2'(idx);
      e.row = (idx == 0) ? 1'b1 : 1'b0;
      e.col = (idx == 0) ? 4'd3 : 4'd9;
      e.ch  = (idx == 0) ? 8'h35 : 8'h41;
      sb.push_back(e);
   endtask

   task automatic wait_ack(input int idx, input int budget);
      logic got;
      got = 1'b0;
      for (int i = 0; i < budget && !got; i++) begin
         tick();
         if (ack_o[idx] === 1'b1) got = 1'b1;
      end
      chk("wait_ack", {31'd0, got}, 32'd1);
   endtask

   task automatic wait_idle(input int budget);
      for (int i = 0; i < budget && active_o !== 1'b0; i++) tick();
      chk("wait_idle", {31'd0, active_o}, 32'd0);
   endtask

   // LCD driver model: busy rises rise_dly cycles after a strobe, stays busy_len cycles.
   always @(negedge CLK) begin
      if (!RST) begin
         m_busy = 1'b0;
         t_v = 0;
         l_v = 0;
      end else if (lcd_we === 1'b1 && auto_en != 0) begin
         t_v = rise_dly;
         l_v = busy_len;
      end else if (t_v > 0) begin
         t_v--;
         if (t_v == 0) m_busy = 1'b1;
      end else if (l_v > 0) begin
         l_v--;
         if (l_v == 0) m_busy = 1'b0;
      end
   end

   // Scoreboard: every strobe must match the oldest expected write; acks are one-hot.
   always @(posedge CLK) begin
      exp_t e;
      #1;
      if (RST === 1'b1 && lcd_we === 1'b1) begin
         chk("sb_avail", {31'd0, (sb.size() > 0)}, 32'd1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("wr_owner", {30'd0, owner_o}, {30'd0, e.own});
            chk("wr_row", {31'd0, lcd_row}, {31'd0, e.row});
            chk("wr_col", {28'd0, lcd_col}, {28'd0, e.col});
            chk("wr_char", {24'd0, lcd_char}, {24'd0, e.ch});
         end
      end
      if (RST === 1'b1 && ack_o !== 2'b00) begin
         chk("ack_onehot", $countones(ack_o), 32'd1);
      end
   end

   initial begin
      int n;
      int k;
      logic raised;

      // Reset state
      tick();
      tick();
      chk("rst_outputs", {14'd0, ack_o, lcd_we, active_o, owner_o, lcd_row, lcd_col, lcd_char},
          32'd0);
      RST = 1'b1;
      tick();

      // 1: single request from requester 0
      auto_en = 1; rise_dly = 3; busy_len = 3;
      push_exp(0);
      req_i = 2'b01;
      tick();                                              // cycle 1
      chk("t1_ack", {30'd0, ack_o}, 32'd1);
      chk("t1_active", {31'd0, active_o}, 32'd1);
      chk("t1_we_early", {31'd0, lcd_we}, 32'd0);
      req_i = 2'b00;
      tick();                                              // cycle 2
      chk("t1_we", {31'd0, lcd_we}, 32'd1);
      chk("t1_data", {19'd0, lcd_row, lcd_col, lcd_char}, {19'd0, 1'b1, 4'd3, 8'h35});
      tick();                                              // cycle 3
      chk("t1_we_pulse", {31'd0, lcd_we}, 32'd0);
      for (int i = 4; i <= 8; i++) tick();                 // cycle 8
      chk("t1_active_busy", {31'd0, active_o}, 32'd1);
      tick();                                              // cycle 9
      chk("t1_active_fall", {31'd0, active_o}, 32'd0);
      chk("t1_data_hold", {19'd0, lcd_row, lcd_col, lcd_char}, {19'd0, 1'b1, 4'd3, 8'h35});

      // 2: both request continuously; pointer is now 1 so 1 goes first
      rise_dly = 2; busy_len = 2;
      push_exp(1); push_exp(0); push_exp(1); push_exp(0);
      req_i = 2'b11;
      n = 0;
      for (int i = 0; i < 200 && n < 4; i++) begin
         tick();
         if (lcd_we === 1'b1) n++;
      end
      req_i = 2'b00;
      chk("t2_writes", n, 32'd4);
      wait_idle(50);

      // 3: requester 0 locks for 4 characters while requester 1 waits
      push_exp(0); push_exp(0); push_exp(0); push_exp(0); push_exp(1);
      req_i = 2'b01;
      lock_i = 2'b01;
      k = 0;
      raised = 1'b0;
      for (int i = 0; i < 400 && k < 4; i++) begin
         tick();
         if (ack_o[0] === 1'b1) begin
            k++;
            if (!raised) begin
               req_i[1] = 1'b1;
               raised = 1'b1;
            end
            if (k == 4) begin
               req_i[0] = 1'b0;
               lock_i[0] = 1'b0;
            end
         end
      end
      chk("t3_lock_grants", k, 32'd4);
      wait_ack(1, 100);
      req_i = 2'b00;
      wait_idle(50);

      // 4: busy never rises -> timeout BUSY_WAIT cycles after the strobe
      auto_en = 0;
      push_exp(1);
      req_i = 2'b10;
      tick();                                              // cycle 1
      chk("t4_ack", {30'd0, ack_o}, 32'd2);
      req_i = 2'b00;
      tick();                                              // cycle 2
      chk("t4_we", {31'd0, lcd_we}, 32'd1);
      tick(); tick(); tick();                              // cycle 5
      chk("t4_active_wait", {31'd0, active_o}, 32'd1);
      tick();                                              // cycle 6
      chk("t4_timeout", {31'd0, active_o}, 32'd0);
      auto_en = 1;
      push_exp(0);
      req_i = 2'b01;
      tick();
      chk("t4_next_ack", {30'd0, ack_o}, 32'd1);
      req_i = 2'b00;
      wait_idle(50);

      // 5: busy held high in IDLE blocks the grant
      push_exp(0);
      force_busy = 1'b1;
      req_i = 2'b01;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t5_no_ack", {30'd0, ack_o}, 32'd0);
         chk("t5_no_we", {31'd0, lcd_we}, 32'd0);
      end
      force_busy = 1'b0;
      tick();
      chk("t5_ack", {30'd0, ack_o}, 32'd1);
      req_i = 2'b00;
      wait_idle(50);

      // 6: reset asserted during WAIT_FALL
      rise_dly = 1; busy_len = 10;
      push_exp(1);
      req_i = 2'b10;
      tick();
      chk("t6_ack", {30'd0, ack_o}, 32'd2);
      req_i = 2'b00;
      tick(); tick(); tick(); tick();                      // cycle 5, in WAIT_FALL
      chk("t6_active_pre", {31'd0, active_o}, 32'd1);
      RST = 1'b0;
      #1;
      chk("t6_rst_outputs", {14'd0, ack_o, lcd_we, active_o, owner_o, lcd_row, lcd_col, lcd_char},
          32'd0);
      tick();
      chk("t6_no_we_a", {31'd0, lcd_we}, 32'd0);
      tick();
      chk("t6_no_we_b", {31'd0, lcd_we}, 32'd0);
      RST = 1'b1;
      rise_dly = 2; busy_len = 2;
      push_exp(0);
      req_i = 2'b11;
      tick();
      chk("t6_first_grant", {30'd0, ack_o}, 32'd1);
      req_i = 2'b00;
      wait_idle(50);
      tick(); tick();
      chk("sb_empty", sb.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
